// File: rtl/stream_fifo.sv
// First-word-fall-through ready/valid FIFO with occupancy and full/empty flags.
// Optional registered almost-full flag: define STREAM_FIFO_ALMOST_FULL_EN.
module stream_fifo #(
    parameter int Width            = 8,
    parameter int Depth            = 4,
    parameter int AlmostFullThresh = Depth - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [Width-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

    // Reject configurations the pointer wrap and flag logic cannot handle.
    if (Depth < 2 || (Depth & (Depth - 1)) != 0 || AlmostFullThresh > Depth ||
        AlmostFullThresh < 0) begin : g_bad_cfg
        $error("stream_fifo: unsupported Depth/AlmostFullThresh");
    end

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_w, pop_w;

    // Flags come from the registered count only, so no input-to-output path.
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign ready_o = ~full_o;
    assign valid_o = ~empty_o;
    assign count_o = count_q;
    assign data_o  = mem[rptr_q];

    assign push_w = valid_i & ready_o;
    assign pop_w  = valid_o & ready_i;

    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_w) wptr_q <= wptr_q + PW'(1);
            if (pop_w)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage is intentionally not reset; data_o is only meaningful with valid_o.
    always_ff @(posedge clk_i) begin
        if (push_w) mem[wptr_q] <= data_i;
    end

`ifdef STREAM_FIFO_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_C = CW'(AlmostFullThresh);
    logic af_q;

    // Evaluated on next-count so the flag lines up with count_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) af_q <= 1'b0;
        else         af_q <= (count_d >= AF_C);
    end

    assign almost_full_o = af_q;
`else
    assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (Width=8, Depth=4).
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       valid_i, ready_i;
    logic [7:0] data_i;
    logic       ready_o, valid_o, full_o, empty_o, almost_full_o;
    logic [7:0] data_o;
    logic [2:0] count_o;

    int checks = 0;
    int failures = 0;

`ifdef STREAM_FIFO_ALMOST_FULL_EN
    localparam logic AF_ON = 1'b1;
`else
    localparam logic AF_ON = 1'b0;
`endif

    stream_fifo #(.Width(8), .Depth(4), .AlmostFullThresh(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        valid_i = 1'b1;
        data_i  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ready_o, valid_o, count_o, empty_o} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got rdy=%b vld=%b cnt=%0d emp=%b want 1 0 0 1",
                         i, ready_o, valid_o, count_o, empty_o);
            end
        end
        rst_ni = 1'b1;
        step();
        checks++;
        if ({valid_o, count_o, data_o} !== {1'b1, 3'd1, 8'h77}) begin
            failures++;
            $display("FAIL reset_first_push got vld=%b cnt=%0d data=%h want 1 1 77",
                     valid_o, count_o, data_o);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if (empty_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_drain got empty=%b want 1", empty_o);
        end
    endtask

    task automatic fill4();
        valid_i = 1'b1;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'h11 * 8'(i + 1);
            step();
        end
        valid_i = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        fill4();
        checks++;
        if ({count_o, full_o, ready_o} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fill_full got cnt=%0d full=%b rdy=%b want 4 1 0",
                     count_o, full_o, ready_o);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'h11 * 8'(i + 1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL drain_order idx=%0d got vld=%b data=%h want 1 %h",
                         i, valid_o, data_o, exp);
            end
            step();
        end
        ready_i = 1'b0;
        checks++;
        if ({empty_o, valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL drain_empty got emp=%b vld=%b want 1 0", empty_o, valid_o);
        end
    endtask

    task automatic test_full_both();
        logic [7:0] exp;
        fill4();
        valid_i = 1'b1;
        data_i  = 8'h55;
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        checks++;
        if ({count_o, full_o, data_o} !== {3'd3, 1'b0, 8'h22}) begin
            failures++;
            $display("FAIL full_both got cnt=%0d full=%b data=%h want 3 0 22",
                     count_o, full_o, data_o);
        end
        for (int i = 0; i < 3; i++) begin
            exp = 8'h22 + 8'h11 * 8'(i);
            checks++;
            if ({valid_o, data_o} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL full_both_drain idx=%0d got vld=%b data=%h want 1 %h",
                         i, valid_o, data_o, exp);
            end
            step();
        end
        ready_i = 1'b0;
        checks++;
        if (empty_o !== 1'b1) begin
            failures++;
            $display("FAIL full_both_empty got empty=%b want 1 (0x55 must be dropped)", empty_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        valid_i = 1'b1;
        ready_i = 1'b0;
        data_i  = 8'h60; step();
        data_i  = 8'h61; step();
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = 8'h62 + 8'(i);
            exp    = 8'h60 + 8'(i);
            checks++;
            if (data_o !== exp) begin
                failures++;
                $display("FAIL stream_data idx=%0d got %h want %h", i, data_o, exp);
            end
            step();
            checks++;
            if (count_o !== 3'd2) begin
                failures++;
                $display("FAIL stream_count idx=%0d got %0d want 2", i, count_o);
            end
        end
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp = 8'h6A + 8'(i);
            checks++;
            if (data_o !== exp) begin
                failures++;
                $display("FAIL stream_tail idx=%0d got %h want %h", i, data_o, exp);
            end
            step();
        end
        ready_i = 1'b0;
        checks++;
        if (empty_o !== 1'b1) begin
            failures++;
            $display("FAIL stream_empty got empty=%b want 1", empty_o);
        end
    endtask

    task automatic test_mid_reset();
        valid_i = 1'b1;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'hC0 + 8'(i);
            step();
        end
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({count_o, valid_o, empty_o, ready_o} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d vld=%b emp=%b rdy=%b want 0 0 1 1",
                     count_o, valid_o, empty_o, ready_o);
        end
        #1 rst_ni = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hA5;
        step();
        valid_i = 1'b0;
        checks++;
        if ({valid_o, data_o, count_o} !== {1'b1, 8'hA5, 3'd1}) begin
            failures++;
            $display("FAIL mid_reset_push got vld=%b data=%h cnt=%0d want 1 a5 1",
                     valid_o, data_o, count_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_almost_full();
        valid_i = 1'b1;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'hE0 + 8'(i);
            step();
            if (i == 1) begin
                checks++;
                if ({count_o, almost_full_o} !== {3'd2, 1'b0}) begin
                    failures++;
                    $display("FAIL af_below got cnt=%0d af=%b want 2 0", count_o, almost_full_o);
                end
            end
        end
        valid_i = 1'b0;
        checks++;
        if ({count_o, almost_full_o} !== {3'd3, AF_ON}) begin
            failures++;
            $display("FAIL af_at_thresh got cnt=%0d af=%b want 3 %b",
                     count_o, almost_full_o, AF_ON);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if ({count_o, almost_full_o} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL af_after_pop got cnt=%0d af=%b want 2 0", count_o, almost_full_o);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_fill_drain();
        test_full_both();
        test_back_to_back();
        test_mid_reset();
        test_almost_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
